// File: rtl/serial_frame_pkg.sv
// Shared types and 7-segment helpers for the button-stepped serial frame controller.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG7_0 = 7'b1000000;
  localparam logic [6:0] SEG7_1 = 7'b1111001;
  localparam logic [6:0] SEG7_2 = 7'b0100100;
  localparam logic [6:0] SEG7_3 = 7'b0110000;
  localparam logic [6:0] SEG7_4 = 7'b0011001;
  localparam logic [6:0] SEG7_5 = 7'b0010010;
  localparam logic [6:0] SEG7_6 = 7'b0000010;
  localparam logic [6:0] SEG7_7 = 7'b1111000;
  localparam logic [6:0] SEG7_8 = 7'b0000000;
  localparam logic [6:0] SEG7_9 = 7'b0010000;
  localparam logic [6:0] SEG7_A = 7'b0001000;
  localparam logic [6:0] SEG7_B = 7'b0000011;
  localparam logic [6:0] SEG7_C = 7'b1000110;
  localparam logic [6:0] SEG7_D = 7'b0100001;
  localparam logic [6:0] SEG7_E = 7'b0000110;
  localparam logic [6:0] SEG7_F = 7'b0001110;

  function automatic logic [6:0] hex_to_seg7(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = SEG7_0;
      4'h1: seg = SEG7_1;
      4'h2: seg = SEG7_2;
      4'h3: seg = SEG7_3;
      4'h4: seg = SEG7_4;
      4'h5: seg = SEG7_5;
      4'h6: seg = SEG7_6;
      4'h7: seg = SEG7_7;
      4'h8: seg = SEG7_8;
      4'h9: seg = SEG7_9;
      4'hA: seg = SEG7_A;
      4'hB: seg = SEG7_B;
      4'hC: seg = SEG7_C;
      4'hD: seg = SEG7_D;
      4'hE: seg = SEG7_E;
      default: seg = SEG7_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/serial_frame_ctrl_btn_one_pulse.sv
// Button synchroniser plus rising-edge detector; emits one pulse per press.
module btn_one_pulse
  import serial_frame_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Reset to 1 so a button held through reset never looks like a new press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(btn_i);
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/serial_frame_ctrl.sv
// Button-stepped serial frame controller: LEN_W-bit length header, then N forwarded bits.
// Optional trailing even-parity check when SERIAL_PARITY_CHK_EN is defined.
module serial_frame_ctrl
  import serial_frame_pkg::*;
#(
  parameter int LEN_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_button,
  input  logic       serIn,
  output logic       serOut,
  output logic       serOutValid,
  output logic [6:0] seg_out,
  output logic       busy,
  output logic       frame_done,
  output logic       parity_err,
  output logic [1:0] dbg_state_o
);

  localparam int CNT_W = (LEN_W > 1) ? $clog2(LEN_W) : 1;

  // serOutValid is a one-cycle strobe qualifying serOut; the sink cannot stall.
  state_e             state_q, state_d;
  logic [LEN_W-1:0]   hdr_q, hdr_d, hdr_next;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   rem_q, rem_d, rem_dec;
  logic               ser_out_q, ser_out_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [6:0]         seg_q, seg_d;
  logic [SYNC_STAGES-1:0] ser_sync_q;
  logic               ser_s;
  logic               step;

  btn_one_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (push_button),
    .pulse_o(step)
  );

  assign ser_s    = ser_sync_q[SYNC_STAGES-1];
  assign hdr_next = (hdr_q << 1) | LEN_W'(ser_s);
  assign rem_dec  = rem_q - LEN_W'(1);

`ifdef SERIAL_PARITY_CHK_EN
  logic par_q, par_d, perr_q, perr_d;
`endif

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    ser_out_d = ser_out_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    seg_d     = seg_q;
`ifdef SERIAL_PARITY_CHK_EN
    par_d     = par_q;
    perr_d    = perr_q;
`endif
    case (state_q)
      HEADER: if (step) begin
        hdr_d = hdr_next;
        cnt_d = cnt_q + CNT_W'(1);
`ifdef SERIAL_PARITY_CHK_EN
        if (cnt_q == '0) perr_d = 1'b0;
`endif
        if (cnt_q == CNT_W'(LEN_W - 1)) begin
          hdr_d = '0;
          cnt_d = '0;
          rem_d = hdr_next;
          if (hdr_next == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = PAYLOAD;
            seg_d   = hex_to_seg7(4'(hdr_next));
`ifdef SERIAL_PARITY_CHK_EN
            par_d   = 1'b0;
`endif
          end
        end
      end
      PAYLOAD: if (step) begin
        ser_out_d = ser_s;
        valid_d   = 1'b1;
        rem_d     = rem_dec;
        seg_d     = hex_to_seg7(4'(rem_dec));
`ifdef SERIAL_PARITY_CHK_EN
        par_d     = par_q ^ ser_s;
        if (rem_q == LEN_W'(1)) state_d = PARITY;
`else
        if (rem_q == LEN_W'(1)) state_d = DONE;
`endif
      end
`ifdef SERIAL_PARITY_CHK_EN
      PARITY: if (step) begin
        par_d   = par_q ^ ser_s;
        state_d = DONE;
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        state_d = HEADER;
        hdr_d   = '0;
        cnt_d   = '0;
        rem_d   = '0;
        seg_d   = SEG7_0;
`ifdef SERIAL_PARITY_CHK_EN
        perr_d  = par_q;
`endif
      end
      default: state_d = HEADER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HEADER;
      hdr_q      <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      ser_out_q  <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      seg_q      <= SEG7_0;
      ser_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      ser_out_q  <= ser_out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      seg_q      <= seg_d;
      ser_sync_q <= (ser_sync_q << 1) | SYNC_STAGES'(serIn);
    end
  end

`ifdef SERIAL_PARITY_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign serOut      = ser_out_q;
  assign serOutValid = valid_q;
  assign frame_done  = done_q;
  assign seg_out     = seg_q;
  assign busy        = (state_q == PAYLOAD) || (state_q == PARITY);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Bench for serial_frame_ctrl: directed frames plus random frames against a frame-level model.
module tb_serial_frame_ctrl;

  localparam int LEN_W = 4;

  logic       clk = 1'b0;
  logic       rst, push_button, serIn;
  logic       serOut, serOutValid, busy, frame_done, parity_err;
  logic [6:0] seg_out;
  logic [1:0] dbg_state;

  serial_frame_ctrl #(.LEN_W(LEN_W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_button(push_button),
    .serIn      (serIn),
    .serOut     (serOut),
    .serOutValid(serOutValid),
    .seg_out    (seg_out),
    .busy       (busy),
    .frame_done (frame_done),
    .parity_err (parity_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  int valid_cnt = 0, exp_valid = 0;
  int done_cnt = 0, exp_done = 0;
  int strobe_cyc = -100, done_cyc = -100;

  // Frame-level model: header bits, remaining payload count, pending parity.
  int hdr_cnt = 0, hdr_val = 0, rem = 0;
  bit par_wait = 0, par_acc = 0, exp_perr = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (serOutValid) begin
        valid_cnt++;
        got_q.push_back(serOut);
        strobe_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    hdr_cnt = 0; hdr_val = 0; rem = 0;
    par_wait = 0; par_acc = 0; exp_perr = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic model_step(input bit b);
    if (rem > 0) begin
      exp_q.push_back(b);
      exp_valid++;
      par_acc ^= b;
      rem--;
      if (rem == 0) begin
`ifdef SERIAL_PARITY_CHK_EN
        par_wait = 1;
`else
        exp_done++;
`endif
      end
    end else if (par_wait) begin
      par_wait = 0;
      exp_perr = par_acc ^ b;
      exp_done++;
    end else begin
      if (hdr_cnt == 0) exp_perr = 0;
      hdr_val = hdr_val * 2 + int'(b);
      hdr_cnt++;
      if (hdr_cnt == LEN_W) begin
        rem = hdr_val;
        hdr_cnt = 0;
        hdr_val = 0;
        par_acc = 0;
        if (rem == 0) exp_done++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_serOut", serOut, 0);
    check("rst_valid", serOutValid, 0);
    check("rst_seg", seg_out, 7'b1000000);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_perr", parity_err, 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic press(input bit b, input int hold);
    int pc;
    bit payload;
    payload = (rem > 0);
    @(negedge clk) serIn = b;
    @(negedge clk) push_button = 1'b1;
    pc = cyc + 1;
    repeat (hold) @(negedge clk);
    push_button = 1'b0;
    repeat (8) @(negedge clk);
    model_step(b);
    check("valid_cnt", valid_cnt, exp_valid);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("ser_bit", got_q.pop_front(), exp_q.pop_front());
    if (payload) check("strobe_lat", strobe_cyc - pc, 2);
    check("seg", seg_out, seg_tab[rem % 16]);
    check("busy", busy, (rem > 0 || par_wait) ? 1 : 0);
    check("done_cnt", done_cnt, exp_done);
    check("perr", parity_err, exp_perr);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input int hold);
    for (int i = n - 1; i >= 0; i--) press(bits[i], hold);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; push_button = 1'b0; serIn = 1'b0;
    do_reset();

    // N=3, payload 1,0,1; frame_done one cycle after the last strobe
    send_bits(32'b0011, 4, 1);
    send_bits(32'b101, 3, 2);
`ifndef SERIAL_PARITY_CHK_EN
    check("done_after_strobe", done_cyc - strobe_cyc, 1);
`endif

    // zero-length frame, then N=1
    send_bits(32'b0000, 4, 1);
    send_bits(32'b0001, 4, 1);
    press(1'b1, 1);
`ifdef SERIAL_PARITY_CHK_EN
    press(1'b1, 1);
`endif

    // long hold during payload
    send_bits(32'b0010, 4, 1);
    press(1'b0, 50);
    press(1'b1, 1);
`ifdef SERIAL_PARITY_CHK_EN
    press(1'b1, 1);
`endif

    // reset after 2 of 5 payload bits, then a fresh header
    send_bits(32'b0101, 4, 1);
    send_bits(32'b11, 2, 1);
    do_reset();
    send_bits(32'b0010, 4, 1);
    send_bits(32'b10, 2, 1);
`ifdef SERIAL_PARITY_CHK_EN
    press(1'b1, 1);
`endif

    // button held across reset deassertion produces no step
    @(negedge clk) serIn = 1'b1; push_button = 1'b1;
    do_reset();
    repeat (10) @(negedge clk);
    push_button = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(32'b0001, 4, 1);
    press(1'b0, 1);
`ifdef SERIAL_PARITY_CHK_EN
    press(1'b0, 1);
    // N=2, payload 1,1: good parity then bad parity held into next header
    send_bits(32'b0010, 4, 1);
    send_bits(32'b110, 3, 1);
    send_bits(32'b0010, 4, 1);
    send_bits(32'b111, 3, 1);
    send_bits(32'b0000, 4, 1);
`endif

    // random frames
    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(0, 15);
      send_bits(32'(n), 4, $urandom_range(1, 4));
      for (int i = 0; i < n; i++) press(1'($urandom_range(0, 1)), $urandom_range(1, 6));
`ifdef SERIAL_PARITY_CHK_EN
      if (n > 0) press(1'($urandom_range(0, 1)), 1);
`endif
    end

    check("final_valid", valid_cnt, exp_valid);
    check("final_done", done_cnt, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
